// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I sequencer: FSM states, opcodes,
// datapath select encodings and the control-word bundle.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        LUI,
        ADDR,
        MEM_RD,
        MEM_WR,
        WB_ALU,
        WB_MEM,
        BRANCH,
        JAL,
        HALT,
        ERROR
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_ALUOUT = 2'b01
    } pc_src_e;

    typedef enum logic [1:0] {
        SA_PC    = 2'b00,
        SA_OLDPC = 2'b01,
        SA_A     = 2'b10,
        SA_ZERO  = 2'b11
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SB_B    = 2'b00,
        SB_IMM  = 2'b01,
        SB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'b00,
        WB_MDR    = 2'b01,
        WB_PC     = 2'b10
    } wb_sel_e;

    typedef struct packed {
        logic       pc_load;
        logic       ir_load;
        logic       ab_load;
        logic       aluout_load;
        logic       mdr_load;
        logic       rf_we;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        pc_src_e    pc_src;
        alu_src_a_e alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        wb_sel_e    wb_sel;
        logic       halted;
        logic       error;
    } ctrl_t;

    // States that own the shared memory port and therefore run the wait timer.
    function automatic logic is_mem_state(input state_e s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

    function automatic logic retires_into_fetch(input state_e s);
        return (s == WB_ALU) || (s == WB_MEM) || (s == MEM_WR) ||
               (s == BRANCH) || (s == JAL);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory wait timer: counts stalled cycles of a memory access and flags
// expiry once MEM_WAIT_MAX stalls have elapsed (MEM_WAIT_MAX = 0 never expires).
module ctrl_wait_timer #(
    parameter int TMR_W        = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam logic [TMR_W-1:0] MAX_C = TMR_W'(MEM_WAIT_MAX);

    if ((2 ** TMR_W) <= MEM_WAIT_MAX) begin : g_bad_width
        $error("ctrl_wait_timer: TMR_W too narrow for MEM_WAIT_MAX");
    end

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (MEM_WAIT_MAX != 0) && (cnt_q == MAX_C);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multi-cycle RV32I datapath, one instruction in flight.
// Optional retired-instruction counter enabled by defining CTRL_INSTRET_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int TMR_W        = 4
`ifdef CTRL_INSTRET_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] opcode,
    input  logic       branch_cond,
    input  logic       mem_ready,
    output logic       pc_load,
    output logic       ir_load,
    output logic       ab_load,
    output logic       aluout_load,
    output logic       mdr_load,
    output logic       rf_we,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic       error
`ifdef CTRL_INSTRET_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    state_e state_q, state_d;
    ctrl_t  ctrl_raw, ctrl_out;
    logic   tmr_clear, tmr_count, tmr_expire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_raw = '0;
        case (state_q)
            FETCH: begin
                ctrl_raw.mem_read  = 1'b1;
                ctrl_raw.iord      = 1'b0;
                ctrl_raw.alu_src_a = SA_PC;
                ctrl_raw.alu_src_b = SB_FOUR;
                ctrl_raw.alu_op    = AOP_ADD;
                if (mem_ready) begin
                    ctrl_raw.ir_load = 1'b1;
                    ctrl_raw.pc_load = 1'b1;
                    ctrl_raw.pc_src  = PC_SEQ;
                    state_d          = DECODE;
                end else if (tmr_expire) begin
                    state_d = ERROR;
                end
            end
            DECODE: begin
                // ALUOut captures OldPC+Imm so BRANCH/JAL can redirect without another ALU pass.
                ctrl_raw.ab_load     = 1'b1;
                ctrl_raw.aluout_load = 1'b1;
                ctrl_raw.alu_src_a   = SA_OLDPC;
                ctrl_raw.alu_src_b   = SB_IMM;
                ctrl_raw.alu_op      = AOP_ADD;
                case (opcode)
                    OP_R:                state_d = EXEC_R;
                    OP_IMM:              state_d = EXEC_I;
                    OP_LUI:              state_d = LUI;
                    OP_LOAD, OP_STORE:   state_d = ADDR;
                    OP_BRANCH:           state_d = BRANCH;
                    OP_JAL:              state_d = JAL;
                    OP_SYSTEM:           state_d = HALT;
                    default:             state_d = ERROR;
                endcase
            end
            EXEC_R: begin
                ctrl_raw.alu_src_a   = SA_A;
                ctrl_raw.alu_src_b   = SB_B;
                ctrl_raw.alu_op      = AOP_FUNCT;
                ctrl_raw.aluout_load = 1'b1;
                state_d              = WB_ALU;
            end
            EXEC_I: begin
                ctrl_raw.alu_src_a   = SA_A;
                ctrl_raw.alu_src_b   = SB_IMM;
                ctrl_raw.alu_op      = AOP_FUNCT;
                ctrl_raw.aluout_load = 1'b1;
                state_d              = WB_ALU;
            end
            LUI: begin
                ctrl_raw.alu_src_a   = SA_ZERO;
                ctrl_raw.alu_src_b   = SB_IMM;
                ctrl_raw.alu_op      = AOP_ADD;
                ctrl_raw.aluout_load = 1'b1;
                state_d              = WB_ALU;
            end
            ADDR: begin
                ctrl_raw.alu_src_a   = SA_A;
                ctrl_raw.alu_src_b   = SB_IMM;
                ctrl_raw.alu_op      = AOP_ADD;
                ctrl_raw.aluout_load = 1'b1;
                state_d              = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                ctrl_raw.mem_read = 1'b1;
                ctrl_raw.iord     = 1'b1;
                if (mem_ready) begin
                    ctrl_raw.mdr_load = 1'b1;
                    state_d           = WB_MEM;
                end else if (tmr_expire) begin
                    state_d = ERROR;
                end
            end
            MEM_WR: begin
                ctrl_raw.mem_write = 1'b1;
                ctrl_raw.iord      = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end else if (tmr_expire) begin
                    state_d = ERROR;
                end
            end
            WB_ALU: begin
                ctrl_raw.rf_we  = 1'b1;
                ctrl_raw.wb_sel = WB_ALUOUT;
                state_d         = FETCH;
            end
            WB_MEM: begin
                ctrl_raw.rf_we  = 1'b1;
                ctrl_raw.wb_sel = WB_MDR;
                state_d         = FETCH;
            end
            BRANCH: begin
                ctrl_raw.alu_src_a = SA_A;
                ctrl_raw.alu_src_b = SB_B;
                ctrl_raw.alu_op    = AOP_SUB;
                if (branch_cond) begin
                    ctrl_raw.pc_load = 1'b1;
                    ctrl_raw.pc_src  = PC_ALUOUT;
                end
                state_d = FETCH;
            end
            JAL: begin
                // PC was already advanced in FETCH, so it holds the link value.
                ctrl_raw.rf_we   = 1'b1;
                ctrl_raw.wb_sel  = WB_PC;
                ctrl_raw.pc_load = 1'b1;
                ctrl_raw.pc_src  = PC_ALUOUT;
                state_d          = FETCH;
            end
            HALT: begin
                ctrl_raw.halted = 1'b1;
            end
            ERROR: begin
                ctrl_raw.error = 1'b1;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
        if (!en) begin
            state_d = state_q;
        end
    end

    // Reset drives every output low at once, independent of the clock.
    always_comb begin
        ctrl_out = ctrl_raw;
        if (!en) begin
            ctrl_out.pc_load     = 1'b0;
            ctrl_out.ir_load     = 1'b0;
            ctrl_out.ab_load     = 1'b0;
            ctrl_out.aluout_load = 1'b0;
            ctrl_out.mdr_load    = 1'b0;
            ctrl_out.rf_we       = 1'b0;
            ctrl_out.mem_read    = 1'b0;
            ctrl_out.mem_write   = 1'b0;
        end
        if (!rst) begin
            ctrl_out = '0;
        end
    end

    assign pc_load     = ctrl_out.pc_load;
    assign ir_load     = ctrl_out.ir_load;
    assign ab_load     = ctrl_out.ab_load;
    assign aluout_load = ctrl_out.aluout_load;
    assign mdr_load    = ctrl_out.mdr_load;
    assign rf_we       = ctrl_out.rf_we;
    assign mem_read    = ctrl_out.mem_read;
    assign mem_write   = ctrl_out.mem_write;
    assign iord        = ctrl_out.iord;
    assign pc_src      = ctrl_out.pc_src;
    assign alu_src_a   = ctrl_out.alu_src_a;
    assign alu_src_b   = ctrl_out.alu_src_b;
    assign alu_op      = ctrl_out.alu_op;
    assign wb_sel      = ctrl_out.wb_sel;
    assign halted      = ctrl_out.halted;
    assign error       = ctrl_out.error;

    // Any state change restarts the timer, so each memory access starts from zero.
    assign tmr_clear = en && (state_d != state_q);
    assign tmr_count = en && is_mem_state(state_q) && !mem_ready;

    ctrl_wait_timer #(
        .TMR_W        (TMR_W),
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (tmr_clear),
        .count_i  (tmr_count),
        .expire_o (tmr_expire)
    );

`ifdef CTRL_INSTRET_EN
    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if (en && (state_d == FETCH) && retires_into_fetch(state_q)) begin
            instret_d = instret_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control-word checks against
// hand-computed vectors; covers CTRL_INSTRET_EN when that macro is defined.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic [6:0] opcode = 7'b0110011;
    logic       branch_cond = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_load, ir_load, ab_load, aluout_load, mdr_load, rf_we;
    logic       mem_read, mem_write, iord, halted, error;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
`ifdef CTRL_INSTRET_EN
    logic [31:0] instret;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .opcode      (opcode),
        .branch_cond (branch_cond),
        .mem_ready   (mem_ready),
        .pc_load     (pc_load),
        .ir_load     (ir_load),
        .ab_load     (ab_load),
        .aluout_load (aluout_load),
        .mdr_load    (mdr_load),
        .rf_we       (rf_we),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .iord        (iord),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .wb_sel      (wb_sel),
        .halted      (halted),
        .error       (error)
`ifdef CTRL_INSTRET_EN
        ,
        .instret     (instret)
`endif
    );

    always #5 clk = ~clk;

    // {pc,ir,ab,aluout,mdr,rf_we,mrd,mwr,iord}, pc_src, src_a, src_b, alu_op, wb_sel, {halted,error}
    logic [20:0] ctl;
    assign ctl = {pc_load, ir_load, ab_load, aluout_load, mdr_load, rf_we,
                  mem_read, mem_write, iord, pc_src, alu_src_a, alu_src_b,
                  alu_op, wb_sel, halted, error};

    localparam logic [20:0] E_ZERO = '0;
    localparam logic [20:0] E_FW   = {9'b000000100, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] E_FR   = {9'b110000100, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] E_F0   = {9'b000000000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] E_DEC  = {9'b001100000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] E_XR   = {9'b000100000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [20:0] E_XI   = {9'b000100000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    localparam logic [20:0] E_LUI  = {9'b000100000, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] E_ADDR = {9'b000100000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] E_MRW  = {9'b000000101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] E_MRR  = {9'b000010101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] E_MWW  = {9'b000000011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] E_MW0  = {9'b000000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] E_WBA  = {9'b000001000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] E_WBM  = {9'b000001000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    localparam logic [20:0] E_BRT  = {9'b100000000, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
    localparam logic [20:0] E_BRN  = {9'b000000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
    localparam logic [20:0] E_JAL  = {9'b100001000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    localparam logic [20:0] E_HLT  = {9'b000000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [20:0] E_ERR  = {9'b000000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Inputs are set before the call; outputs sampled mid-cycle, then one clock.
    task automatic cyc(input string tag, input logic [20:0] exp);
        #2;
        chk(tag, {11'b0, ctl}, {11'b0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #2;
        chk(tag, {11'b0, ctl}, {11'b0, E_ZERO});
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

`ifdef CTRL_INSTRET_EN
    task automatic run_op(input logic [6:0] op, input int ncyc);
        opcode = op;
        repeat (ncyc) begin
            @(posedge clk);
            #1;
        end
    endtask
`endif

    initial begin
        #3;
        do_reset("reset");

        opcode = 7'b0110011;
        cyc("add_fetch", E_FR);  cyc("add_dec", E_DEC);
        cyc("add_exec", E_XR);   cyc("add_wb", E_WBA);

        opcode = 7'b0010011;
        cyc("addi_fetch", E_FR); cyc("addi_dec", E_DEC);
        cyc("addi_exec", E_XI);  cyc("addi_wb", E_WBA);

        opcode = 7'b0110111;
        cyc("lui_fetch", E_FR);  cyc("lui_dec", E_DEC);
        cyc("lui_exec", E_LUI);  cyc("lui_wb", E_WBA);

        opcode = 7'b0000011;
        cyc("lw_fetch", E_FR);   cyc("lw_dec", E_DEC);   cyc("lw_addr", E_ADDR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_memwait", E_MRW);
        mem_ready = 1'b1;
        cyc("lw_memrdy", E_MRR); cyc("lw_wb", E_WBM);

        opcode = 7'b0100011;
        cyc("sw_fetch", E_FR);   cyc("sw_dec", E_DEC);   cyc("sw_addr", E_ADDR);
        mem_ready = 1'b0;
        cyc("sw_memwait", E_MWW);
        en = 1'b0;
        cyc("sw_en0_a", E_MW0);  cyc("sw_en0_b", E_MW0);
        en = 1'b1;
        mem_ready = 1'b1;
        cyc("sw_memrdy", E_MWW);

        opcode = 7'b1100011;
        branch_cond = 1'b1;
        cyc("beqt_fetch", E_FR); cyc("beqt_dec", E_DEC); cyc("beqt_br", E_BRT);
        branch_cond = 1'b0;
        cyc("beqn_fetch", E_FR); cyc("beqn_dec", E_DEC); cyc("beqn_br", E_BRN);

        opcode = 7'b1101111;
        cyc("jal_fetch", E_FR);  cyc("jal_dec", E_DEC);  cyc("jal_exec", E_JAL);
        mem_ready = 1'b0;
        cyc("jal_back", E_FW);

        // Fetch timeout: 16 stalled cycles, then sticky ERROR.
        do_reset("tmo_reset");
        for (int i = 0; i < 16; i++) cyc("tmo_wait", E_FW);
        cyc("tmo_err", E_ERR);
        mem_ready = 1'b1;
        cyc("tmo_sticky", E_ERR);

        // Ready on the 16th cycle beats expiry.
        mem_ready = 1'b0;
        do_reset("edge_reset");
        for (int i = 0; i < 15; i++) cyc("edge_wait", E_FW);
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        cyc("edge_rdy", E_FR);
        cyc("edge_dec", E_DEC);

        do_reset("bad_reset");
        opcode = 7'b1111111;
        cyc("bad_fetch", E_FR);  cyc("bad_dec", E_DEC);
        cyc("bad_err", E_ERR);   cyc("bad_sticky", E_ERR);
        do_reset("bad_rst");
        mem_ready = 1'b0;
        cyc("bad_refetch", E_FW);

        do_reset("hlt_reset");
        mem_ready = 1'b1;
        opcode = 7'b1110011;
        cyc("hlt_fetch", E_FR);  cyc("hlt_dec", E_DEC);
        cyc("hlt_halt", E_HLT);  cyc("hlt_sticky", E_HLT);
        do_reset("hlt_rst");
        mem_ready = 1'b0;
        cyc("hlt_refetch", E_FW);

`ifdef CTRL_INSTRET_EN
        do_reset("ir_reset");
        chk("ir_zero", instret, 32'd0);
        mem_ready = 1'b1;
        run_op(7'b0110011, 4); run_op(7'b0010011, 4); run_op(7'b0110111, 4);
        run_op(7'b0000011, 5); run_op(7'b0100011, 4); run_op(7'b1100011, 3);
        run_op(7'b1101111, 3); run_op(7'b0110011, 4); run_op(7'b0000011, 5);
        run_op(7'b1100011, 3);
        chk("ir_ten", instret, 32'd10);
        opcode = 7'b0110011;
        en = 1'b0;
        cyc("ir_en0_a", E_F0);   cyc("ir_en0_b", E_F0);
        chk("ir_frozen", instret, 32'd10);
        en = 1'b1;
        cyc("ir_resume", E_FR);  cyc("ir_dec", E_DEC);
        cyc("ir_exec", E_XR);    cyc("ir_wb", E_WBA);
        chk("ir_eleven", instret, 32'd11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
